// File: rtl/tcp_pkg.sv
// Shared TCP control definitions: state codes and flag-pulse bundle.
package tcp_pkg;

  localparam int unsigned StateW = 5;

  // State codes are shared with the active-open block; keep values fixed.
  typedef enum logic [StateW-1:0] {
    StClosed    = 5'd0,
    StListen    = 5'd1,
    StSynRcvd   = 5'd3,
    StEstab     = 5'd4,
    StFinWait1  = 5'd5,
    StFinWait2  = 5'd6,
    StClosing   = 5'd7,
    StCloseWait = 5'd8,
    StLastAck   = 5'd9,
    StTimeWait  = 5'd10
  } tcp_state_e;

  // One-cycle request pulses to the packet builder.
  typedef struct packed {
    logic syn_ack;
    logic ack;
    logic fin;
    logic rst;
  } tcp_flags_t;

  // States in which the shared timer runs (RTO or 2MSL).
  function automatic logic is_timed_state(tcp_state_e s);
    return (s == StSynRcvd) || (s == StFinWait1) || (s == StLastAck) || (s == StTimeWait);
  endfunction

endpackage

// File: rtl/tcp_timer.sv
// 16-bit up-counter with clear/enable and a zero-selects-default limit.
module tcp_timer #(
  parameter logic [15:0] DEFAULT_RTO  = 16'h0400,
  parameter logic [15:0] DEFAULT_2MSL = 16'h1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        sel_2msl,
  input  logic [15:0] rto_cfg,
  input  logic [15:0] msl_cfg,
  output logic        expired
);

  logic [15:0] count_q;
  logic [15:0] limit;

  // Limit follows the register bank every cycle; zero means use the default.
  always_comb begin
    limit = 16'd0;
    if (sel_2msl) begin
      limit = (msl_cfg == 16'd0) ? DEFAULT_2MSL : msl_cfg;
    end else begin
      limit = (rto_cfg == 16'd0) ? DEFAULT_RTO : rto_cfg;
    end
    expired = enable && (count_q == limit);
  end

  // Count while enabled, otherwise park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else if (clear) begin
      count_q <= 16'd0;
    end else if (enable) begin
      count_q <= count_q + 16'd1;
    end else begin
      count_q <= 16'd0;
    end
  end

endmodule

// File: rtl/tcp_passive_control.sv
// Passive-open (responder) TCP connection FSM with RTO retransmit and 2MSL TIME_WAIT.
module tcp_passive_control
  import tcp_pkg::*;
#(
  parameter logic [15:0] DEFAULT_RTO        = 16'h0400,
  parameter logic [15:0] DEFAULT_2MSL_TIMER = 16'h1000,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rto_in,
  input  logic [15:0] timeout_2msl_in,
  input  logic        listen_en,
  input  logic        close_req,
  input  logic        syn_rcvd,
  input  logic        ack_rcvd,
  input  logic        fin_rcvd,
  input  logic        rst_rcvd,
  output logic        syn_ack_send,
  output logic        ack_send,
  output logic        fin_send,
  output logic        rst_send,
  output logic [4:0]  state_out,
  output logic        connection_established,
  output logic        error_flag
);

  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

  tcp_state_e        state_q, state_d;
  tcp_flags_t        flags_q, flags_d;
  logic [RetryW-1:0] retries_q, retries_d;
  logic              err_q, err_d;
  logic              conn_q;
  logic              retx;
  logic              restart;
  logic              give_up;
  logic              timer_exp;
  logic              timer_clear;
  logic              timer_en;

  assign timer_en    = is_timed_state(state_q);
  assign timer_clear = (state_d != state_q) || retx || restart;
  assign give_up     = (retries_q == RetryMax);

  tcp_timer #(
    .DEFAULT_RTO  (DEFAULT_RTO),
    .DEFAULT_2MSL (DEFAULT_2MSL_TIMER)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .enable   (timer_en),
    .sel_2msl (state_q == StTimeWait),
    .rto_cfg  (rto_in),
    .msl_cfg  (timeout_2msl_in),
    .expired  (timer_exp)
  );

  // Next state, send pulses and error flag; rst_rcvd beats expiry beats the rest,
  // except that an ack arriving on the expiry cycle beats the retransmit.
  always_comb begin
    state_d   = state_q;
    flags_d   = '0;
    err_d     = err_q;
    retx      = 1'b0;
    restart   = 1'b0;
    retries_d = retries_q;
    case (state_q)
      StClosed: begin
        if (listen_en) state_d = StListen;
      end
      StListen: begin
        if (syn_rcvd) begin
          state_d         = StSynRcvd;
          flags_d.syn_ack = 1'b1;
          err_d           = 1'b0;
        end else if (!listen_en) begin
          state_d = StClosed;
        end
      end
      StSynRcvd: begin
        if (rst_rcvd) begin
          state_d = StListen;
        end else if (ack_rcvd) begin
          state_d = StEstab;
        end else if (timer_exp) begin
          if (give_up) begin
            state_d     = StListen;
            flags_d.rst = 1'b1;
            err_d       = 1'b1;
          end else begin
            flags_d.syn_ack = 1'b1;
            retx            = 1'b1;
          end
        end else if (close_req) begin
          state_d     = StFinWait1;
          flags_d.fin = 1'b1;
        end
      end
      StEstab: begin
        if (rst_rcvd) begin
          state_d = StClosed;
        end else if (close_req && fin_rcvd) begin
          state_d     = StClosing;
          flags_d.fin = 1'b1;
          flags_d.ack = 1'b1;
        end else if (close_req) begin
          state_d     = StFinWait1;
          flags_d.fin = 1'b1;
        end else if (fin_rcvd) begin
          state_d     = StCloseWait;
          flags_d.ack = 1'b1;
        end
      end
      StFinWait1: begin
        if (rst_rcvd) begin
          state_d = StClosed;
        end else if (fin_rcvd && ack_rcvd) begin
          state_d     = StTimeWait;
          flags_d.ack = 1'b1;
        end else if (ack_rcvd) begin
          state_d = StFinWait2;
        end else if (timer_exp) begin
          if (give_up) begin
            state_d     = StClosed;
            flags_d.rst = 1'b1;
            err_d       = 1'b1;
          end else begin
            flags_d.fin = 1'b1;
            retx        = 1'b1;
          end
        end else if (fin_rcvd) begin
          state_d     = StClosing;
          flags_d.ack = 1'b1;
        end
      end
      StFinWait2: begin
        if (rst_rcvd) begin
          state_d = StClosed;
        end else if (fin_rcvd) begin
          state_d     = StTimeWait;
          flags_d.ack = 1'b1;
        end
      end
      StClosing: begin
        if (rst_rcvd) begin
          state_d = StClosed;
        end else if (ack_rcvd) begin
          state_d = StTimeWait;
        end
      end
      StCloseWait: begin
        if (rst_rcvd) begin
          state_d = StClosed;
        end else if (close_req) begin
          state_d     = StLastAck;
          flags_d.fin = 1'b1;
        end
      end
      StLastAck: begin
        if (rst_rcvd) begin
          state_d = StClosed;
        end else if (ack_rcvd) begin
          state_d = StClosed;
        end else if (timer_exp) begin
          if (give_up) begin
            state_d     = StClosed;
            flags_d.rst = 1'b1;
            err_d       = 1'b1;
          end else begin
            flags_d.fin = 1'b1;
            retx        = 1'b1;
          end
        end
      end
      StTimeWait: begin
        if (timer_exp) begin
          state_d = StClosed;
        end else if (fin_rcvd) begin
          flags_d.ack = 1'b1;
          restart     = 1'b1;
        end
      end
      default: state_d = StClosed;
    endcase

    // Retries survive retransmits but reset on any state change.
    if (state_d != state_q) begin
      retries_d = '0;
    end else if (retx) begin
      retries_d = retries_q + RetryW'(1);
    end
  end

  // State and all outputs are registered on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClosed;
      flags_q   <= '0;
      retries_q <= '0;
      err_q     <= 1'b0;
      conn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      retries_q <= retries_d;
      err_q     <= err_d;
      conn_q    <= (state_d == StEstab);
    end
  end

  assign state_out              = state_q;
  assign syn_ack_send           = flags_q.syn_ack;
  assign ack_send               = flags_q.ack;
  assign fin_send               = flags_q.fin;
  assign rst_send               = flags_q.rst;
  assign connection_established = conn_q;
  assign error_flag             = err_q;

endmodule

// File: tb/tb_tcp_passive_control.sv
// Scoreboard bench for tcp_passive_control: directed handshake/close/abort cases plus random traffic.
module tb_tcp_passive_control;

  localparam int MaxRetries = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rto_in, timeout_2msl_in;
  logic        listen_en, close_req, syn_rcvd, ack_rcvd, fin_rcvd, rst_rcvd;
  logic        syn_ack_send, ack_send, fin_send, rst_send;
  logic [4:0]  state_out;
  logic        connection_established, error_flag;

  tcp_passive_control #(
    .DEFAULT_RTO        (16'h0400),
    .DEFAULT_2MSL_TIMER (16'h1000),
    .MAX_RETRIES        (MaxRetries)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .rto_in                 (rto_in),
    .timeout_2msl_in        (timeout_2msl_in),
    .listen_en              (listen_en),
    .close_req              (close_req),
    .syn_rcvd               (syn_rcvd),
    .ack_rcvd               (ack_rcvd),
    .fin_rcvd               (fin_rcvd),
    .rst_rcvd               (rst_rcvd),
    .syn_ack_send           (syn_ack_send),
    .ack_send               (ack_send),
    .fin_send               (fin_send),
    .rst_send               (rst_send),
    .state_out              (state_out),
    .connection_established (connection_established),
    .error_flag             (error_flag)
  );

  always #5 clk = ~clk;

  // Expected view of the outputs after one clock edge; fl = {syn_ack, ack, fin, rst}.
  typedef struct packed {
    logic [4:0] st;
    logic [3:0] fl;
    logic       est;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sa_cnt = 0;
  int   rst_cnt = 0;

  // Reference model: connection phase, cycles spent waiting, resend count, sticky error.
  int m_st, m_age, m_retries;
  bit m_err;

  task automatic model_reset();
    m_st = 0; m_age = 0; m_retries = 0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit l, c, s, a, f, r, output exp_t e);
    int  ns, limit;
    bit  timed, expd, retry_evt, retx, restart;
    bit  p_sa, p_a, p_f, p_r;
    ns = m_st; retry_evt = 0; retx = 0; restart = 0;
    p_sa = 0; p_a = 0; p_f = 0; p_r = 0;
    timed = (m_st == 3) || (m_st == 5) || (m_st == 9) || (m_st == 10);
    if (m_st == 10) limit = (timeout_2msl_in == 0) ? 4096 : int'(timeout_2msl_in);
    else            limit = (rto_in == 0) ? 1024 : int'(rto_in);
    expd = timed && (m_age == limit);
    case (m_st)
      0: if (l) ns = 1;
      1: if (s) begin ns = 3; p_sa = 1; m_err = 0; end else if (!l) ns = 0;
      3: if (r) ns = 1; else if (a) ns = 4; else if (expd) retry_evt = 1;
         else if (c) begin ns = 5; p_f = 1; end
      4: if (r) ns = 0; else if (c && f) begin ns = 7; p_f = 1; p_a = 1; end
         else if (c) begin ns = 5; p_f = 1; end else if (f) begin ns = 8; p_a = 1; end
      5: if (r) ns = 0; else if (f && a) begin ns = 10; p_a = 1; end else if (a) ns = 6;
         else if (expd) retry_evt = 1; else if (f) begin ns = 7; p_a = 1; end
      6: if (r) ns = 0; else if (f) begin ns = 10; p_a = 1; end
      7: if (r) ns = 0; else if (a) ns = 10;
      8: if (r) ns = 0; else if (c) begin ns = 9; p_f = 1; end
      9: if (r) ns = 0; else if (a) ns = 0; else if (expd) retry_evt = 1;
      10: if (expd) ns = 0; else if (f) begin p_a = 1; restart = 1; end
      default: ns = 0;
    endcase
    if (retry_evt) begin
      if (m_retries < MaxRetries) begin
        if (m_st == 3) p_sa = 1; else p_f = 1;
        m_retries++;
        retx = 1;
      end else begin
        p_r = 1; m_err = 1;
        ns = (m_st == 3) ? 1 : 0;
      end
    end
    if (ns != m_st) m_retries = 0;
    if (ns != m_st || retx || restart) m_age = 0;
    else if (timed) m_age++;
    else m_age = 0;
    m_st  = ns;
    e.st  = 5'(ns);
    e.fl  = {p_sa, p_a, p_f, p_r};
    e.est = (ns == 4);
    e.err = m_err;
  endtask

  // Drive one cycle of inputs and queue the response the model predicts for it.
  task automatic step(input bit l, c, s, a, f, r);
    exp_t e;
    @(negedge clk);
    listen_en = l; close_req = c; syn_rcvd = s; ack_rcvd = a; fin_rcvd = f; rst_rcvd = r;
    model_step(l, c, s, a, f, r, e);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit l);
    for (int i = 0; i < n; i++) step(l, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, got, got, want, want,
               $time);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Drain pending expectations, pulse reset asynchronously and check the outputs drop at once.
  task automatic do_reset(input string name);
    settle();
    rst_n = 1'b0;
    #1;
    check(name, {state_out, syn_ack_send, ack_send, fin_send, rst_send,
                 connection_established, error_flag}, 0);
    listen_en = 0; close_req = 0; syn_rcvd = 0; ack_rcvd = 0; fin_rcvd = 0; rst_rcvd = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: one scoreboard entry per clock edge while out of reset.
  always @(posedge clk) begin
    #1;
    if (syn_ack_send) sa_cnt++;
    if (rst_send) rst_cnt++;
    if (rst_n && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_cmp++;
      if ({state_out, syn_ack_send, ack_send, fin_send, rst_send, connection_established,
           error_flag} !== mon_e) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t got st=%0d fl=%b%b%b%b est=%b err=%b want st=%0d fl=%b est=%b err=%b",
                 $time, state_out, syn_ack_send, ack_send, fin_send, rst_send,
                 connection_established, error_flag, mon_e.st, mon_e.fl, mon_e.est, mon_e.err);
      end
    end
  end

  initial begin
    int sa0, rst0;
    rst_n = 1'b0;
    rto_in = 16'd16; timeout_2msl_in = 16'd32;
    listen_en = 0; close_req = 0; syn_rcvd = 0; ack_rcvd = 0; fin_rcvd = 0; rst_rcvd = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", {state_out, syn_ack_send, ack_send, fin_send, rst_send,
                            connection_established, error_flag}, 0);
    rst_n = 1'b1;

    // Handshake: syn on the 5th cycle, ack four cycles later.
    idle(4, 1);
    step(1, 0, 1, 0, 0, 0);
    idle(3, 1);
    step(1, 0, 0, 1, 0, 0);
    settle();
    check("handshake_state", state_out, 4);
    check("handshake_estab", connection_established, 1);

    // Passive close.
    step(1, 0, 0, 0, 1, 0);
    idle(2, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    settle();
    check("passive_close_state", state_out, 0);

    // Retry exhaustion in SYN_RCVD with rto 16.
    step(1, 0, 0, 0, 0, 0);
    sa0 = sa_cnt; rst0 = rst_cnt;
    step(1, 0, 1, 0, 0, 0);
    idle(70, 1);
    settle();
    check("retry_synack_count", sa_cnt - sa0, 4);
    check("retry_rst_count", rst_cnt - rst0, 1);
    check("retry_state", state_out, 1);
    check("retry_error_flag", error_flag, 1);

    // Simultaneous close, then TIME_WAIT restart on a late fin.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(10, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(32, 0);
    settle();
    check("time_wait_restarted", state_out, 10);
    idle(1, 0);
    settle();
    check("time_wait_expired", state_out, 0);

    // Peer reset in FIN_WAIT_2.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    settle();
    check("rst_in_fw2_state", state_out, 0);
    check("rst_in_fw2_pulses", {syn_ack_send, ack_send, fin_send, rst_send}, 0);

    // Async reset while in SYN_RCVD.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    idle(3, 1);
    do_reset("reset_in_syn_rcvd");

    // Default RTO: first retransmit 1025 cycles after syn_ack.
    rto_in = 16'd0;
    step(1, 0, 0, 0, 0, 0);
    sa0 = sa_cnt;
    step(1, 0, 1, 0, 0, 0);
    idle(1030, 1);
    settle();
    check("default_rto_synacks", sa_cnt - sa0, 2);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);

    // Random traffic in blocks; configuration only changes across a reset.
    for (int b = 0; b < 6; b++) begin
      do_reset("reset_block");
      rto_in          = 16'($urandom_range(2, 12));
      timeout_2msl_in = 16'($urandom_range(3, 20));
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
      end
    end

    settle();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
